// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of one shared combinational ALU; one op per 3 cycles.
// Round-robin by default; define ALU_ARBITER_FIXED_PRIO_EN to always favour port 0.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int CTR_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [CTR_W-1:0] req0_ctr,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [CTR_W-1:0] req1_ctr,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [CTR_W-1:0] alu_ctr,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_less,
   input  logic             alu_zero,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_less,
   output logic             rsp_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   owner;
   logic   last_grant;
   logic   pick1;
   logic   gnt0, gnt1;
   logic   rsp_hs;

   always_comb begin
      pick1     = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rsp_hs    = 1'b0;
      state_nxt = state;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
      pick1 = req1_valid && !req0_valid;
`else
      // On a tie, the port that did not win last time goes first.
      pick1 = req1_valid && (!req0_valid || (last_grant == 1'b0));
`endif

      if (state == IDLE && !reset) begin
         gnt0 = req0_valid && !pick1;
         gnt1 = req1_valid && pick1;
      end

      rsp_hs = owner ? rsp1_ready : rsp0_ready;

      case (state)
         IDLE:    if (gnt0 || gnt1) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) && owner;
   assign busy       = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctr    <= '0;
         rsp_data   <= '0;
         rsp_less   <= 1'b0;
         rsp_zero   <= 1'b0;
      end else begin
         state <= state_nxt;
         // Operands only move on an accept, so the ALU inputs stay quiet otherwise.
         if (gnt0 || gnt1) begin
            owner      <= gnt1;
            last_grant <= gnt1;
            alu_a      <= gnt1 ? req1_a   : req0_a;
            alu_b      <= gnt1 ? req1_b   : req0_b;
            alu_ctr    <= gnt1 ? req1_ctr : req0_ctr;
         end
         if (state == EXEC) begin
            rsp_data <= alu_out;
            rsp_less <= alu_less;
            rsp_zero <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model, directed scenarios and random traffic.
module tb_alu_arbiter;
   localparam int W  = 32;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [CW-1:0] req0_ctr = '0, req1_ctr = '0;
   logic [W-1:0]  alu_a, alu_b, alu_out;
   logic [CW-1:0] alu_ctr;
   logic          alu_less, alu_zero;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic [W-1:0]  rsp_data;
   logic          rsp_less, rsp_zero, busy;

   always #5 clock = ~clock;

   alu_arbiter #(.WIDTH(W), .CTR_W(CW)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctr(req0_ctr),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctr(req1_ctr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
      .alu_out(alu_out), .alu_less(alu_less), .alu_zero(alu_zero),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .rsp_less(rsp_less), .rsp_zero(rsp_zero), .busy(busy)
   );

   // Stand-in ALU: returns {less, zero, out}
   function automatic logic [W+1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [CW-1:0] c);
      logic [W-1:0] o;
      logic         l;
      l = (c == 4'b0011) ? (a < b) : ($signed(a) < $signed(b));
      case (c)
         4'b0000: o = a + b;
         4'b1000: o = a - b;
         4'b0010, 4'b0011: begin o = '0; o[0] = l; end
         4'b0111: o = a & b;
         4'b0110: o = a | b;
         4'b0100: o = a ^ b;
         default: o = a;
      endcase
      return {l, (o == '0), o};
   endfunction

   assign {alu_less, alu_zero, alu_out} = alu_f(alu_a, alu_b, alu_ctr);

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one transaction in flight, tracked by its age since accept
   bit            m_pend = 0, m_owner = 0, m_last = 1;
   int            m_age = 0;
   logic [W-1:0]  m_a = '0, m_b = '0;
   logic [CW-1:0] m_c = '0;
   logic [W+1:0]  m_exp = '0, m_vis = '0;
   bit            acc0 = 0, acc1 = 0;
   int            grant_q[$];
   int            grant_cyc[$];
   int            cyc_n = 0;

   always @(negedge clock) begin
      bit e0, e1;
      cyc_n++;
      e0 = 0;
      e1 = 0;
      if (!reset && !m_pend) begin
         if (req0_valid && req1_valid) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            e1 = 0;
`else
            e1 = !m_last;
`endif
            e0 = !e1;
         end else begin
            e0 = req0_valid;
            e1 = req1_valid;
         end
      end
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("busy", busy, m_pend);
      chk("rsp0_valid", rsp0_valid, m_pend && m_age >= 2 && !m_owner);
      chk("rsp1_valid", rsp1_valid, m_pend && m_age >= 2 && m_owner);
      chk("rsp_data", rsp_data, m_vis[W-1:0]);
      chk("rsp_zero", rsp_zero, m_vis[W]);
      chk("rsp_less", rsp_less, m_vis[W+1]);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_ctr", alu_ctr, m_c);
      acc0 = e0 && req0_valid;
      acc1 = e1 && req1_valid;
      if (reset) begin
         m_pend = 0; m_last = 1; m_owner = 0; m_age = 0;
         m_a = '0; m_b = '0; m_c = '0; m_vis = '0;
         acc0 = 0; acc1 = 0;
      end else if (acc0 || acc1) begin
         m_pend  = 1;
         m_age   = 1;
         m_owner = acc1;
         m_last  = acc1;
         m_a     = acc1 ? req1_a : req0_a;
         m_b     = acc1 ? req1_b : req0_b;
         m_c     = acc1 ? req1_ctr : req0_ctr;
         m_exp   = alu_f(m_a, m_b, m_c);
         grant_q.push_back(int'(acc1));
         grant_cyc.push_back(cyc_n);
      end else if (m_pend) begin
         if (m_age == 1) begin
            m_age = 2;
            m_vis = m_exp;
         end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_pend = 0;
         end
      end
   end

   logic [CW-1:0] ops [6] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111, 4'b0110};

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [CW-1:0] c);
      if (p == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_ctr = c; end
      else        begin req1_valid = 1; req1_a = a; req1_b = b; req1_ctr = c; end
   endtask

   task automatic rand_req(input int p);
      logic [W-1:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      set_req(p, a, b, ops[$urandom_range(0, 5)]);
   endtask

   // Called at posedge+1; returns after the response cycle's closing edge
   task automatic do_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [CW-1:0] c, output logic [W-1:0] d,
                        output logic l, output logic z, output int lat);
      bit got;
      d = '0; l = 0; z = 0; lat = -1;
      set_req(p, a, b, c);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if (p == 0 ? req0_ready : req1_ready) got = 1;
      end
      cyc();
      if (p == 0) req0_valid = 0; else req1_valid = 0;
      if (!got) begin chk("accept_timeout", 0, 1); return; end
      got = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clock);
         if (p == 0 ? rsp0_valid : rsp1_valid) begin
            got = 1; lat = i; d = rsp_data; l = rsp_less; z = rsp_zero;
         end
      end
      if (!got) chk("rsp_timeout", 0, 1);
      cyc();
   endtask

   // Let outstanding requests be served, then wait for idle
   task automatic drain();
      for (int i = 0; i < 40 && (req0_valid || req1_valid || busy); i++) begin
         cyc();
         if (acc0) req0_valid = 0;
         if (acc1) req1_valid = 0;
      end
      chk("drain_idle", busy, 0);
   endtask

   initial begin
      logic [W-1:0] d, held;
      logic         l, z;
      int           lat, k;
      bit           got;

      // Reset then a single subtract on port 0
      set_req(0, 32'd5, 32'd3, 4'b1000);
      rsp0_ready = 1; rsp1_ready = 1;
      cyc();
      @(negedge clock);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_rsp_data", rsp_data, 0);
      cyc();
      reset = 0;
      do_op(0, 32'd5, 32'd3, 4'b1000, d, l, z, lat);
      chk("sub_latency", lat, 2);
      chk("sub_data", d, 32'd2);
      chk("sub_zero", z, 0);
      @(negedge clock);
      chk("sub_idle_after", busy, 0);
      cyc();

      // Contention: both valid continuously
      reset = 1; cyc(); reset = 0;
      k = grant_q.size();
      rand_req(0); rand_req(1);
      for (int i = 0; i < 13; i++) begin
         cyc();
         if (acc0) rand_req(0);
         if (acc1) rand_req(1);
      end
      drain();
      if (grant_q.size() >= k + 4) begin
         chk("rr_g0", grant_q[k], 0);
         chk("rr_g1", grant_q[k+1], 1);
         chk("rr_g2", grant_q[k+2], 0);
         chk("rr_g3", grant_q[k+3], 1);
         chk("rr_spacing", grant_cyc[k+1] - grant_cyc[k], 3);
      end else chk("rr_grant_count", grant_q.size() - k, 4);

      // Response backpressure on port 1
      rsp1_ready = 0;
      set_req(1, 32'd100, 32'd40, 4'b1000);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin cyc(); if (acc1) got = 1; end
      req1_valid = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clock); if (rsp1_valid) got = 1; end
      chk("bp_rsp1_seen", got, 1);
      held = rsp_data;
      chk("bp_data", held, 32'd60);
      cyc();
      set_req(0, 32'd1, 32'd2, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp_rsp1_valid", rsp1_valid, 1);
         chk("bp_data_stable", rsp_data, held);
         chk("bp_req0_ready", req0_ready, 0);
         cyc();
      end
      set_req(1, 32'd9, 32'd9, 4'b0111);
      rsp1_ready = 1;
      cyc();
      @(negedge clock);
      chk("bp_release_req0", req0_ready, 1);
      chk("bp_release_req1", req1_ready, 0);
      drain();

      // Flags
      cyc();
      do_op(1, 32'hFFFF_FFFF, 32'd1, 4'b0010, d, l, z, lat);
      chk("slt_less", l, 1);
      chk("slt_data", d, 32'd1);
      do_op(1, 32'd7, 32'd7, 4'b1000, d, l, z, lat);
      chk("eq_zero", z, 1);
      chk("eq_data", d, 32'd0);

      // Reset while a response is pending
      rsp0_ready = 0;
      set_req(0, 32'd3, 32'd4, 4'b0110);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clock); if (rsp0_valid) got = 1; end
      chk("rr_rsp0_seen", got, 1);
      cyc();
      req0_valid = 0;
      reset = 1;
      set_req(0, 32'd11, 32'd1, 4'b0000);
      set_req(1, 32'd22, 32'd2, 4'b0000);
      @(negedge clock);
      chk("rstmid_gate0", req0_ready, 0);
      chk("rstmid_gate1", req1_ready, 0);
      cyc();
      reset = 0;
      rsp0_ready = 1;
      @(negedge clock);
      chk("rstmid_rsp0", rsp0_valid, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_alu_a", alu_a, 0);
      chk("rstmid_data", rsp_data, 0);
      chk("rstmid_grant0", req0_ready, 1);
      drain();

`ifdef ALU_ARBITER_FIXED_PRIO_EN
      k = grant_q.size();
      rand_req(0); rand_req(1);
      while (grant_q.size() < k + 4 && cyc_n < 20000) begin
         cyc();
         if (acc0) rand_req(0);
      end
      for (int i = 0; i < 4; i++) chk("fixed_g0", grant_q[k+i], 0);
      drain();
      chk("fixed_then_g1", grant_q[grant_q.size()-1], 1);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if (acc0 || !req0_valid) begin
            if ($urandom_range(0, 99) < 60) rand_req(0); else req0_valid = 0;
         end
         if (acc1 || !req1_valid) begin
            if ($urandom_range(0, 99) < 60) rand_req(1); else req1_valid = 0;
         end
         rsp0_ready = ($urandom_range(0, 99) < 70);
         rsp1_ready = ($urandom_range(0, 99) < 70);
         reset = ($urandom_range(0, 199) == 0);
      end
      reset = 0;
      rsp0_ready = 1; rsp1_ready = 1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
